hsv_to_rgb_pipe: RTL
====================

Name: hsv_to_rgb_pipe

Overview:
- Pipelined, parametrised HSV→RGB converter with valid/ready streaming on input and output.
- Converts hue in degrees (0..359) and saturation/value in percent (0..100) to RGB channels scaled to 0..2^OUT_W-1.
- Flags out-of-range inputs and passes a sideband tag through with each sample.
- Sits between the colour-generation logic and the LED/pixel output drivers; sustains one pixel per clock when not back-pressured.

Parameters:
- H_W, 9, hue input width; must hold 359.
- P_W, 7, saturation/value input width; must hold 100.
- OUT_W, 8, width of each R/G/B output; OUT_MAX = 2^OUT_W-1.
- TAG_W, 4, sideband tag width, carried unchanged through the pipe.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts an input this cycle.
- hue  in  H_W  hue, degrees.
- saturation  in  P_W  saturation, percent.
- value  in  P_W  value, percent.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- r, g, b  out  OUT_W each  RGB result.
- out_tag  out  TAG_W  tag of the output sample.
- out_err  out  1  the output sample had out-of-range input.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits, r/g/b, out_tag and out_err clear to 0.
  - in_ready = 1 once reset deasserts.
  - Reset mid-operation discards all in-flight samples; nothing from before reset is ever presented.
- Pipeline and handshake:
  - Four register stages S1..S4; S4 drives the outputs directly.
  - Global advance enable: en = !out_valid | out_ready. in_ready = en, driven combinationally.
  - A transfer occurs when in_valid & in_ready (input side) or out_valid & out_ready (output side).
  - When en = 0, every stage holds, including its data and valid bits.
  - When en = 1, every stage shifts. A stage with a bubble becomes invalid; no compaction is required.
  - Latency: an accepted sample appears on the outputs exactly 4 cycles later when out_ready stays high.
  - Throughput: 1 sample per clock.
  - Outputs are stable while out_valid & !out_ready.
- Arithmetic: all integer, truncating division, intermediates at least P_W+H_W+OUT_W bits unsigned.
  - S1:
    - Register the inputs and tag.
    - err = (hue > 359) | (saturation > 100) | (value > 100).
    - sector = hue/60 (0..5).
    - frac = hue%60.
  - S2: vmin = (100 - saturation) * value / 100.
  - S3:
    - a = (value - vmin) * frac / 60.
    - vinc = vmin + a.
    - vdec = value - a.
    - Carry value and vmin forward.
  - S4:
    - Sector select, then scale each channel: x_out = x * OUT_MAX / 100.
    - Sector mapping (R,G,B): 0 (V,vinc,vmin); 1 (vdec,V,vmin); 2 (vmin,V,vinc); 3 (vmin,vdec,V); 4 (vinc,vmin,V); 5 (V,vmin,vdec).
  - If err = 1: r = g = b = 0, out_err = 1, tag still passed. The sample still occupies a slot and is not dropped.
- Boundaries:
  - hue = 359 is valid (sector 5, frac 59).
  - saturation = 0 gives r = g = b = scaled value.
  - value = 0 gives all channels 0.
  - value = 100 with OUT_W = 8 gives 255 exactly.
  - Simultaneous input and output transfers in the same cycle are normal streaming.
  - in_valid = 0 while en = 1 inserts a bubble.
- No combinational path from in_valid to out_valid. The only combinational path is out_ready → in_ready.

Test Plan:
- Reset, then hue=0, sat=100, val=100, tag=3, out_ready=1 → 4 cycles later r=255, g=0, b=0, out_tag=3, out_err=0.
- Stream back-to-back (120,100,100), (30,100,100), (200,50,80), (77,0,50) → consecutive cycles produce (0,255,0), (255,127,0), (102,170,204), (127,127,127).
- Same stream with out_ready held low for 3 cycles after the first output:
  - in_ready low during the stall.
  - Output held stable.
  - No sample lost or duplicated; order preserved.
- hue=360, sat=50, val=50 → out_err=1, rgb=0. The following valid sample (0,100,100) → (255,0,0), out_err=0.
- Assert reset asynchronously (mid-cycle) with 3 samples in flight → outputs clear immediately, out_valid=0. After release, no stale sample emerges and the next input has latency 4.
- Sweep hue 0..359 at sat=100, val=100 with random out_ready → every output matches a reference model of the integer formulas; count out == count in.

Source files
------------

// File: rtl/hsv_to_rgb_pipe.sv
// Four-stage HSV (degrees / percent) to RGB converter with valid/ready streaming.
// One global enable advances or freezes every stage together; S4 drives the outputs.
module hsv_to_rgb_pipe #(
  parameter int unsigned H_W   = 9,
  parameter int unsigned P_W   = 7,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [H_W-1:0]   hue,
  input  logic [P_W-1:0]   saturation,
  input  logic [P_W-1:0]   value,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] r,
  output logic [OUT_W-1:0] g,
  output logic [OUT_W-1:0] b,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam int unsigned IW     = P_W + H_W + OUT_W;
  localparam int unsigned SEC_W  = 3;
  localparam int unsigned FRAC_W = 6;
  localparam logic [IW-1:0] OUT_MAX = {{(IW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [IW-1:0] PCT_MAX = IW'(100);
  localparam logic [IW-1:0] DEG_SEC = IW'(60);
  localparam logic [IW-1:0] HUE_MAX = IW'(359);

  logic en;

  logic               s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
  logic [P_W-1:0]     s1_sat_q, s1_sat_d, s1_val_q, s1_val_d;
  logic [SEC_W-1:0]   s1_sector_q, s1_sector_d;
  logic [FRAC_W-1:0]  s1_frac_q, s1_frac_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

  logic               s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
  logic [P_W-1:0]     s2_val_q, s2_val_d, s2_vmin_q, s2_vmin_d;
  logic [SEC_W-1:0]   s2_sector_q, s2_sector_d;
  logic [FRAC_W-1:0]  s2_frac_q, s2_frac_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  logic               s3_valid_q, s3_valid_d, s3_err_q, s3_err_d;
  logic [P_W-1:0]     s3_val_q, s3_val_d, s3_vmin_q, s3_vmin_d;
  logic [P_W-1:0]     s3_vinc_q, s3_vinc_d, s3_vdec_q, s3_vdec_d;
  logic [P_W-1:0]     s3_a;
  logic [SEC_W-1:0]   s3_sector_q, s3_sector_d;
  logic [TAG_W-1:0]   s3_tag_q, s3_tag_d;

  logic               out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [OUT_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [P_W-1:0]     r_sel, g_sel, b_sel;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  function automatic logic [OUT_W-1:0] scale(input logic [P_W-1:0] x);
    scale = OUT_W'((IW'(x) * OUT_MAX) / PCT_MAX);
  endfunction

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // S1: capture inputs, range check, split hue into sector and offset
  always_comb begin
    s1_valid_d  = in_valid;
    s1_err_d    = (IW'(hue) > HUE_MAX) || (IW'(saturation) > PCT_MAX) ||
                  (IW'(value) > PCT_MAX);
    s1_sector_d = SEC_W'(IW'(hue) / DEG_SEC);
    s1_frac_d   = FRAC_W'(IW'(hue) % DEG_SEC);
    s1_sat_d    = saturation;
    s1_val_d    = value;
    s1_tag_d    = in_tag;
  end

  // S2: darkest channel level
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_err_d    = s1_err_q;
    s2_sector_d = s1_sector_q;
    s2_frac_d   = s1_frac_q;
    s2_val_d    = s1_val_q;
    s2_tag_d    = s1_tag_q;
    s2_vmin_d   = P_W'(((PCT_MAX - IW'(s1_sat_q)) * IW'(s1_val_q)) / PCT_MAX);
  end

  // S3: rising and falling ramps within the sector
  always_comb begin
    s3_valid_d  = s2_valid_q;
    s3_err_d    = s2_err_q;
    s3_sector_d = s2_sector_q;
    s3_tag_d    = s2_tag_q;
    s3_val_d    = s2_val_q;
    s3_vmin_d   = s2_vmin_q;
    s3_a        = P_W'(((IW'(s2_val_q) - IW'(s2_vmin_q)) * IW'(s2_frac_q)) / DEG_SEC);
    s3_vinc_d   = s2_vmin_q + s3_a;
    s3_vdec_d   = s2_val_q - s3_a;
  end

  // S4: sector mapping, scaling to the output range, error squash
  always_comb begin
    r_sel = s3_val_q;
    g_sel = s3_vinc_q;
    b_sel = s3_vmin_q;
    case (s3_sector_q)
      3'd1:    begin r_sel = s3_vdec_q; g_sel = s3_val_q;  b_sel = s3_vmin_q; end
      3'd2:    begin r_sel = s3_vmin_q; g_sel = s3_val_q;  b_sel = s3_vinc_q; end
      3'd3:    begin r_sel = s3_vmin_q; g_sel = s3_vdec_q; b_sel = s3_val_q;  end
      3'd4:    begin r_sel = s3_vinc_q; g_sel = s3_vmin_q; b_sel = s3_val_q;  end
      3'd5:    begin r_sel = s3_val_q;  g_sel = s3_vmin_q; b_sel = s3_vdec_q; end
      default: begin r_sel = s3_val_q;  g_sel = s3_vinc_q; b_sel = s3_vmin_q; end
    endcase
    out_valid_d = s3_valid_q;
    out_err_d   = s3_err_q;
    out_tag_d   = s3_tag_q;
    r_d         = s3_err_q ? '0 : scale(r_sel);
    g_d         = s3_err_q ? '0 : scale(g_sel);
    b_d         = s3_err_q ? '0 : scale(b_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0; s1_err_q <= 1'b0; s1_sat_q <= '0; s1_val_q <= '0;
      s1_sector_q <= '0; s1_frac_q <= '0; s1_tag_q <= '0;
      s2_valid_q <= 1'b0; s2_err_q <= 1'b0; s2_val_q <= '0; s2_vmin_q <= '0;
      s2_sector_q <= '0; s2_frac_q <= '0; s2_tag_q <= '0;
      s3_valid_q <= 1'b0; s3_err_q <= 1'b0; s3_val_q <= '0; s3_vmin_q <= '0;
      s3_vinc_q <= '0; s3_vdec_q <= '0; s3_sector_q <= '0; s3_tag_q <= '0;
      out_valid_q <= 1'b0; out_err_q <= 1'b0; out_tag_q <= '0;
      r_q <= '0; g_q <= '0; b_q <= '0;
    end else if (en) begin
      s1_valid_q <= s1_valid_d; s1_err_q <= s1_err_d; s1_sat_q <= s1_sat_d;
      s1_val_q <= s1_val_d; s1_sector_q <= s1_sector_d; s1_frac_q <= s1_frac_d;
      s1_tag_q <= s1_tag_d;
      s2_valid_q <= s2_valid_d; s2_err_q <= s2_err_d; s2_val_q <= s2_val_d;
      s2_vmin_q <= s2_vmin_d; s2_sector_q <= s2_sector_d; s2_frac_q <= s2_frac_d;
      s2_tag_q <= s2_tag_d;
      s3_valid_q <= s3_valid_d; s3_err_q <= s3_err_d; s3_val_q <= s3_val_d;
      s3_vmin_q <= s3_vmin_d; s3_vinc_q <= s3_vinc_d; s3_vdec_q <= s3_vdec_d;
      s3_sector_q <= s3_sector_d; s3_tag_q <= s3_tag_d;
      out_valid_q <= out_valid_d; out_err_q <= out_err_d; out_tag_q <= out_tag_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_tag   = out_tag_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;

endmodule
